// File: rtl/aes_pkg.sv
// Shared AES constants, scheduler state type and GF(2^8) helpers.
`include "aes_defines.svh"

package aes_pkg;

    localparam int AES_ROUNDS = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_READY
    } ks_state_e;

    localparam logic [`AES_BYTE_SIZE-1:0] RCON [0:AES_ROUNDS] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [`AES_BYTE_SIZE-1:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant; enough for both MixColumns matrices.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] c);
        logic [7:0] a2, a4, a8;
        a2 = xtime(a);
        a4 = xtime(a2);
        a8 = xtime(a4);
        return (c[0] ? a : 8'h00) ^ (c[1] ? a2 : 8'h00) ^ (c[2] ? a4 : 8'h00) ^ (c[3] ? a8 : 8'h00);
    endfunction

    function automatic logic [`AES_WORD_SIZE-1:0] sub_word(input logic [`AES_WORD_SIZE-1:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

endpackage

// File: rtl/aes_columns_mixer.sv
// MixColumns (Encrypt=1) or InvMixColumns (Encrypt=0) over a 128-bit state.
`include "aes_defines.svh"

module aes_columns_mixer
    import aes_pkg::*;
(
    input  logic                       Encrypt,
    input  logic [`AES_BLOCK_SIZE-1:0] Data_in,
    output logic [`AES_BLOCK_SIZE-1:0] Data_out
);

    // First row of the circulant matrix; later rows are rotations of it.
    logic [3:0] m0, m1, m2, m3;

    assign m0 = Encrypt ? 4'd2 : 4'd14;
    assign m1 = Encrypt ? 4'd3 : 4'd11;
    assign m2 = Encrypt ? 4'd1 : 4'd13;
    assign m3 = Encrypt ? 4'd1 : 4'd9;

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a [4];
        for (genvar r = 0; r < 4; r++) begin : g_byte
            assign a[r] = Data_in[127-32*c-8*r -: 8];
        end
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign Data_out[127-32*c-8*r -: 8] = gf_mul(a[r], m0) ^ gf_mul(a[(r+1)%4], m1)
                                               ^ gf_mul(a[(r+2)%4], m2) ^ gf_mul(a[(r+3)%4], m3);
        end
    end

endmodule

// File: rtl/aes_defines.svh
// Shared AES width macros used by the key scheduler and round datapath.
`ifndef AES_DEFINES_SVH
`define AES_DEFINES_SVH
`define AES_BLOCK_SIZE 128
`define AES_WORD_SIZE 32
`define AES_BYTE_SIZE 8
`endif

// File: rtl/aes_key_expansion_step.sv
// One AES-128 key expansion round: RotWord, SubWord, Rcon and word chaining.
`include "aes_defines.svh"

module aes_key_expansion_step
    import aes_pkg::*;
(
    input  logic [`AES_BLOCK_SIZE-1:0] prev_key,
    input  logic [`AES_BYTE_SIZE-1:0]  rcon,
    output logic [`AES_BLOCK_SIZE-1:0] next_key
);

    logic [`AES_WORD_SIZE-1:0] w0, w1, w2, w3, temp, n0, n1, n2, n3;

    assign w0 = prev_key[127:96];
    assign w1 = prev_key[95:64];
    assign w2 = prev_key[63:32];
    assign w3 = prev_key[31:0];

    assign temp = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h000000};

    assign n0 = w0 ^ temp;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_scheduler.sv
// AES-128 round key scheduler: expands a key once into an 11-entry buffer,
// then replays it in encrypt or equivalent-inverse-cipher decrypt order.
`include "aes_defines.svh"

module aes_key_scheduler
    import aes_pkg::*;
(
    input  logic                       Clk,
    input  logic                       Rst_n,
    input  logic                       Key_valid,
    output logic                       Key_ready,
    input  logic [`AES_BLOCK_SIZE-1:0] Key,
    input  logic                       Start,
    input  logic                       Encrypt,
    input  logic                       Next,
    output logic [`AES_BLOCK_SIZE-1:0] Round_key,
    output logic                       Round_key_valid,
    output logic [3:0]                 Round_num,
    output logic                       Last
);

    localparam logic [3:0] LAST_RN = 4'(AES_ROUNDS);

    ks_state_e state_q, state_d;
    logic [3:0] exp_cnt_q, exp_cnt_d;
    logic [3:0] round_num_q, round_num_d;
    logic       rkv_q, rkv_d;
    logic       enc_q, enc_d;

    logic [`AES_BLOCK_SIZE-1:0] rk_q [0:AES_ROUNDS];
    logic [`AES_BLOCK_SIZE-1:0] rk_d [0:AES_ROUNDS];

    logic [`AES_BLOCK_SIZE-1:0] step_out, sel_key, inv_key;
    logic [3:0] rd_idx;
    logic       load;

    // exp_cnt_q is the source entry; the step writes entry exp_cnt_q+1.
    aes_key_expansion_step u_step (
        .prev_key (rk_q[exp_cnt_q]),
        .rcon     (RCON[exp_cnt_q + 4'd1]),
        .next_key (step_out)
    );

    assign Key_ready = (state_q != ST_EXPAND);

    always_comb begin
        state_d     = state_q;
        exp_cnt_d   = exp_cnt_q;
        round_num_d = round_num_q;
        rkv_d       = rkv_q;
        enc_d       = enc_q;
        rk_d        = rk_q;
        load        = Key_valid && Key_ready;

        if (load) begin
            rk_d[0] = Key;
        end else if (state_q == ST_EXPAND) begin
            rk_d[exp_cnt_q + 4'd1] = step_out;
        end

        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    state_d   = ST_EXPAND;
                    exp_cnt_d = 4'd0;
                end
            end
            ST_EXPAND: begin
                exp_cnt_d = exp_cnt_q + 4'd1;
                if (exp_cnt_q == LAST_RN - 4'd1) state_d = ST_READY;
            end
            ST_READY: begin
                // A new key beats Start, which beats Next.
                if (load) begin
                    state_d     = ST_EXPAND;
                    exp_cnt_d   = 4'd0;
                    rkv_d       = 1'b0;
                    round_num_d = 4'd0;
                end else if (Start) begin
                    enc_d       = Encrypt;
                    round_num_d = 4'd0;
                    rkv_d       = 1'b1;
                end else if (Next && rkv_q) begin
                    if (round_num_q < LAST_RN) begin
                        round_num_d = round_num_q + 4'd1;
                    end else begin
                        rkv_d       = 1'b0;
                        round_num_d = 4'd0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q     <= ST_IDLE;
            exp_cnt_q   <= 4'd0;
            round_num_q <= 4'd0;
            rkv_q       <= 1'b0;
            enc_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            exp_cnt_q   <= exp_cnt_d;
            round_num_q <= round_num_d;
            rkv_q       <= rkv_d;
            enc_q       <= enc_d;
        end
    end

    // Key buffer is not reset; it is only read after a completed expansion.
    always_ff @(posedge Clk) begin
        rk_q <= rk_d;
    end

    assign rd_idx = enc_q ? round_num_q : (LAST_RN - round_num_q);
    assign sel_key = rk_q[rd_idx];

    aes_columns_mixer u_inv_mix (
        .Encrypt  (1'b0),
        .Data_in  (sel_key),
        .Data_out (inv_key)
    );

    always_comb begin
        Round_key = '0;
        if (rkv_q) begin
            if (!enc_q && round_num_q != 4'd0 && round_num_q != LAST_RN) Round_key = inv_key;
            else Round_key = sel_key;
        end
    end

    assign Round_key_valid = rkv_q;
    assign Round_num       = round_num_q;
    assign Last            = rkv_q && (round_num_q == LAST_RN);

endmodule

// File: tb/tb_aes_key_scheduler.sv
// Self-checking bench for aes_key_scheduler against an arithmetic AES key model.
module tb_aes_key_scheduler;

    logic         Clk = 1'b0;
    logic         Rst_n = 1'b0;
    logic         Key_valid = 1'b0;
    logic         Start = 1'b0;
    logic         Encrypt = 1'b0;
    logic         Next = 1'b0;
    logic [127:0] Key = '0;
    logic         Key_ready, Round_key_valid, Last;
    logic [127:0] Round_key;
    logic [3:0]   Round_num;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    aes_key_scheduler dut (
        .Clk             (Clk),
        .Rst_n           (Rst_n),
        .Key_valid       (Key_valid),
        .Key_ready       (Key_ready),
        .Key             (Key),
        .Start           (Start),
        .Encrypt         (Encrypt),
        .Next            (Next),
        .Round_key       (Round_key),
        .Round_key_valid (Round_key_valid),
        .Round_num       (Round_num),
        .Last            (Last)
    );

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK2 = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    // ---------------- reference model (FIPS-197 pseudocode, GF arithmetic) ----
    logic [7:0]   sb [256];
    logic [127:0] m_rk [11];

    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] m_rotl(input logic [7:0] b, input int k);
        logic [7:0] r;
        r = b;
        for (int i = 0; i < k; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    task automatic m_build_sbox();
        logic [7:0] x, inv;
        for (int v = 0; v < 256; v++) begin
            x = 8'(v);
            inv = 8'h00;
            if (v != 0) begin
                inv = x;
                for (int e = 0; e < 253; e++) inv = m_mul(inv, x);
            end
            sb[v] = inv ^ m_rotl(inv, 1) ^ m_rotl(inv, 2) ^ m_rotl(inv, 3) ^ m_rotl(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic m_expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = m_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] m_invmix(input logic [127:0] s);
        int coef [4] = '{14, 11, 13, 9};
        logic [127:0] res;
        logic [7:0] acc;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ m_mul(s[127-32*c-8*j -: 8], 8'(coef[(j - r + 4) % 4]));
                res[127-32*c-8*r -: 8] = acc;
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] m_expect(input logic enc, input int n);
        if (enc) return m_rk[n];
        if (n == 0) return m_rk[10];
        if (n == 10) return m_rk[0];
        return m_invmix(m_rk[10-n]);
    endfunction

    // ---------------- helpers ------------------------------------------------
    task automatic tick();
        @(negedge Clk);
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load_key(input logic [127:0] k);
        Key = k;
        Key_valid = 1'b1;
        tick();
        Key_valid = 1'b0;
    endtask

    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (!Key_ready && cnt < 50) begin
            cnt++;
            tick();
        end
    endtask

    task automatic start_seq(input logic enc);
        Start = 1'b1;
        Encrypt = enc;
        tick();
        Start = 1'b0;
    endtask

    task automatic next_pulse();
        Next = 1'b1;
        tick();
        Next = 1'b0;
    endtask

    task automatic seek(input logic enc, input int n);
        start_seq(enc);
        for (int i = 0; i < n; i++) next_pulse();
    endtask

    task automatic check_out(input string tag, input logic enc, input int n);
        check({tag, "_key"}, Round_key, m_expect(enc, n));
        check({tag, "_num"}, 128'(Round_num), 128'(n));
        check({tag, "_vld"}, 128'(Round_key_valid), 128'(1));
        check({tag, "_last"}, 128'(Last), 128'(n == 10));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_vld"}, 128'(Round_key_valid), 128'(0));
        check({tag, "_key"}, Round_key, 128'(0));
        check({tag, "_num"}, 128'(Round_num), 128'(0));
        check({tag, "_last"}, 128'(Last), 128'(0));
    endtask

    typedef struct {
        string        name;
        logic         enc;
        int           n;
        logic [127:0] key;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vecs[$];
        int cnt;
        logic enc;
        logic [127:0] kr;

        m_build_sbox();

        vecs.push_back('{"enc_r0", 1'b1, 0, FIPS_KEY});
        vecs.push_back('{"enc_r1", 1'b1, 1, FIPS_RK1});
        vecs.push_back('{"enc_r2", 1'b1, 2, FIPS_RK2});
        vecs.push_back('{"enc_r10", 1'b1, 10, FIPS_RK10});
        vecs.push_back('{"dec_r0", 1'b0, 0, FIPS_RK10});
        vecs.push_back('{"dec_r9", 1'b0, 9, m_invmix(FIPS_RK1)});
        vecs.push_back('{"dec_r10", 1'b0, 10, FIPS_KEY});

        // Reset
        tick();
        tick();
        Rst_n = 1'b1;
        check("rst_ready", 128'(Key_ready), 128'(1));
        check_idle_outputs("rst");

        // Start/Next while idle are ignored
        start_seq(1'b1);
        next_pulse();
        check("idle_start_vld", 128'(Round_key_valid), 128'(0));

        // FIPS-197 expansion, then table of known round keys
        m_expand(FIPS_KEY);
        load_key(FIPS_KEY);
        wait_ready(cnt);
        check("fips_ready_cycles", 128'(cnt), 128'(10));
        foreach (vecs[i]) begin
            seek(vecs[i].enc, vecs[i].n);
            check({vecs[i].name, "_key"}, Round_key, vecs[i].key);
            check({vecs[i].name, "_num"}, 128'(Round_num), 128'(vecs[i].n));
            check({vecs[i].name, "_vld"}, 128'(Round_key_valid), 128'(1));
            check({vecs[i].name, "_last"}, 128'(Last), 128'(vecs[i].n == 10));
        end

        // End of sequence, then Next while invalid
        seek(1'b1, 10);
        check("eos_last", 128'(Last), 128'(1));
        next_pulse();
        check_idle_outputs("eos");
        next_pulse();
        check_idle_outputs("eos_extra_next");
        check("eos_ready", 128'(Key_ready), 128'(1));

        // Start and Next together at round 5: Start wins, decrypt re-latched
        seek(1'b1, 5);
        Start = 1'b1;
        Next = 1'b1;
        Encrypt = 1'b0;
        tick();
        Start = 1'b0;
        Next = 1'b0;
        check_out("start_next", 1'b0, 0);

        // Key load and Start together in READY: load wins
        kr = {$urandom, $urandom, $urandom, $urandom};
        m_expand(kr);
        Key = kr;
        Key_valid = 1'b1;
        Start = 1'b1;
        Encrypt = 1'b1;
        tick();
        Key_valid = 1'b0;
        Start = 1'b0;
        check("load_start_ready", 128'(Key_ready), 128'(0));
        check("load_start_vld", 128'(Round_key_valid), 128'(0));
        wait_ready(cnt);
        check("load_start_cycles", 128'(cnt), 128'(10));
        check("load_start_vld_after", 128'(Round_key_valid), 128'(0));
        seek(1'b1, 10);
        check_out("load_start_r10", 1'b1, 10);

        // Key_valid, Start and Next during EXPAND are ignored
        kr = {$urandom, $urandom, $urandom, $urandom};
        m_expand(kr);
        load_key(kr);
        repeat (3) tick();
        Key = ~kr;
        Key_valid = 1'b1;
        Start = 1'b1;
        tick();
        Key_valid = 1'b0;
        Start = 1'b0;
        next_pulse();
        wait_ready(cnt);
        check("exp_ignore_cycles", 128'(cnt + 5), 128'(10));
        check("exp_ignore_vld", 128'(Round_key_valid), 128'(0));
        seek(1'b0, 3);
        check_out("exp_ignore_dec3", 1'b0, 3);

        // Reset during expansion, then a fresh load
        kr = {$urandom, $urandom, $urandom, $urandom};
        load_key(kr);
        repeat (3) tick();
        Rst_n = 1'b0;
        tick();
        Rst_n = 1'b1;
        check("midrst_ready", 128'(Key_ready), 128'(1));
        check_idle_outputs("midrst");
        kr = {$urandom, $urandom, $urandom, $urandom};
        m_expand(kr);
        load_key(kr);
        wait_ready(cnt);
        check("midrst_cycles", 128'(cnt), 128'(10));
        seek(1'b1, 7);
        check_out("midrst_enc7", 1'b1, 7);

        // Random keys: full walks in both directions with idle gaps between Next
        for (int k = 0; k < 3; k++) begin
            kr = {$urandom, $urandom, $urandom, $urandom};
            m_expand(kr);
            load_key(kr);
            wait_ready(cnt);
            check("rand_cycles", 128'(cnt), 128'(10));
            enc = 1'($urandom_range(0, 1));
            for (int e = 0; e < 2; e++) begin
                start_seq(enc);
                for (int n = 0; n <= 10; n++) begin
                    check_out("rand", enc, n);
                    repeat ($urandom_range(0, 2)) tick();
                    check_out("rand_hold", enc, n);
                    if (n < 10) next_pulse();
                end
                next_pulse();
                check_idle_outputs("rand_end");
                enc = ~enc;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
